// File: rtl/game_pkg.sv
// Shared constants, lane state and grade encodings for the rhythm-game hit judge.
package game_pkg;

    localparam int LANES = 5;

    localparam logic [9:0] H_PARK  = 10'd720;
    localparam logic [9:0] GOOD_LO = 10'd620;
    localparam logic [9:0] GOOD_HI = 10'd699;
    localparam logic [9:0] PERF_LO = 10'd645;
    localparam logic [9:0] PERF_HI = 10'd674;
    localparam logic [9:0] MISS_H  = 10'd700;

    localparam int PERF_PTS = 2;
    localparam int GOOD_PTS = 1;

    localparam logic [13:0] SCORE_MAX = 14'd9999;
    localparam logic [7:0]  COMBO_MAX = 8'd255;

    typedef enum logic {
        IDLE,
        ARMED
    } lane_state_t;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_GOOD = 2'd1,
        G_PERF = 2'd2,
        G_MISS = 2'd3
    } grade_t;

endpackage

// File: rtl/lane_judge.sv
// One key lane: tracks the falling block, detects spawns and presses, and grades them.
module lane_judge
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       restart,
    input  logic       stop_or_endgame,
    input  logic [9:0] block_h,
    input  logic       key,
    output grade_t     grade,
    output grade_t     judge
);

    lane_state_t state, state_d;
    logic [9:0]  prev_h;
    logic        key_q;
    logic        spawn, press, in_perf, in_good;

    assign spawn   = block_h < prev_h;
    assign press   = key & ~key_q;
    assign in_perf = (block_h >= PERF_LO) && (block_h <= PERF_HI);
    assign in_good = (block_h >= GOOD_LO) && (block_h <= GOOD_HI);

    // A spawn outranks everything: an unjudged old block is a miss, the new one is armed.
    always_comb begin
        state_d = state;
        judge   = G_NONE;
        if (!stop_or_endgame) begin
            if (spawn) begin
                if (state == ARMED) begin
                    judge = G_MISS;
                end
                state_d = ARMED;
            end else if (state == ARMED) begin
                if (block_h >= MISS_H) begin
                    judge   = G_MISS;
                    state_d = IDLE;
                end else if (press && in_perf) begin
                    judge   = G_PERF;
                    state_d = IDLE;
                end else if (press && in_good) begin
                    judge   = G_GOOD;
                    state_d = IDLE;
                end
            end
        end
    end

    // prev_h and key_q track even while frozen so a held key cannot fire on resume.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            state  <= IDLE;
            grade  <= G_NONE;
            prev_h <= H_PARK;
            key_q  <= 1'b0;
        end else begin
            state  <= state_d;
            grade  <= judge;
            prev_h <= block_h;
            key_q  <= key;
        end
    end

endmodule

// File: rtl/hit_judge.sv
// Top level: per-lane judges, pulse decode and saturating score/combo/max-combo counters.
module hit_judge
    import game_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 restart,
    input  logic                 stop_or_endgame,
    input  logic [10*LANES-1:0]  block_h,
    input  logic [LANES-1:0]     key,
    output logic [LANES-1:0]     hit_perf,
    output logic [LANES-1:0]     hit_good,
    output logic [LANES-1:0]     miss,
    output logic [13:0]          score,
    output logic [7:0]           combo,
    output logic [7:0]           max_combo
);

    grade_t grade [LANES];
    grade_t judge [LANES];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_judge u_lane (
            .clk             (clk),
            .rst             (rst),
            .restart         (restart),
            .stop_or_endgame (stop_or_endgame),
            .block_h         (block_h[10*i +: 10]),
            .key             (key[i]),
            .grade           (grade[i]),
            .judge           (judge[i])
        );
    end

    always_comb begin
        hit_perf = '0;
        hit_good = '0;
        miss     = '0;
        for (int i = 0; i < LANES; i++) begin
            hit_perf[i] = (grade[i] == G_PERF);
            hit_good[i] = (grade[i] == G_GOOD);
            miss[i]     = (grade[i] == G_MISS);
        end
    end

    logic [2:0]  n_perf, n_good, n_hit;
    logic        any_miss;
    logic [14:0] score_sum;
    logic [8:0]  combo_sum;
    logic [13:0] score_d;
    logic [7:0]  combo_d, max_d;

    // Counters use this cycle's judgments so they land on the same edge as the pulses.
    always_comb begin
        n_perf   = '0;
        n_good   = '0;
        any_miss = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (judge[i] == G_PERF) n_perf = n_perf + 3'd1;
            if (judge[i] == G_GOOD) n_good = n_good + 3'd1;
            if (judge[i] == G_MISS) any_miss = 1'b1;
        end
        n_hit     = n_perf + n_good;
        score_sum = 15'(score) + 15'(n_perf) * 15'(PERF_PTS) + 15'(n_good) * 15'(GOOD_PTS);
        score_d   = (score_sum > 15'(SCORE_MAX)) ? SCORE_MAX : score_sum[13:0];
        combo_sum = any_miss ? 9'(n_hit) : 9'(combo) + 9'(n_hit);
        combo_d   = (combo_sum > 9'(COMBO_MAX)) ? COMBO_MAX : combo_sum[7:0];
        max_d     = (combo_d > max_combo) ? combo_d : max_combo;
    end

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            score     <= '0;
            combo     <= '0;
            max_combo <= '0;
        end else begin
            score     <= score_d;
            combo     <= combo_d;
            max_combo <= max_d;
        end
    end

endmodule

// File: tb/tb_hit_judge.sv
// Directed self-checking bench for hit_judge using hand-computed expected values.
module tb_hit_judge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        restart = 1'b0;
    logic        stop_or_endgame = 1'b0;
    logic [49:0] block_h = {5{10'd720}};
    logic [4:0]  key = '0;
    logic [4:0]  hit_perf, hit_good, miss;
    logic [13:0] score;
    logic [7:0]  combo, max_combo;

    int tests_run = 0;
    int tests_failed = 0;

    hit_judge dut (
        .clk             (clk),
        .rst             (rst),
        .restart         (restart),
        .stop_or_endgame (stop_or_endgame),
        .block_h         (block_h),
        .key             (key),
        .hit_perf        (hit_perf),
        .hit_good        (hit_good),
        .miss            (miss),
        .score           (score),
        .combo           (combo),
        .max_combo       (max_combo)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic setH(input int lane, input int v);
        block_h[lane*10 +: 10] = 10'(v);
    endtask

    task automatic setAllH(input int v);
        for (int i = 0; i < 5; i++) setH(i, v);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [4:0] ep, input logic [4:0] eg,
                            input logic [4:0] em, input int es, input int ec, input int emx);
        checkOutput({tag, ".hit_perf"}, 32'(hit_perf), 32'(ep));
        checkOutput({tag, ".hit_good"}, 32'(hit_good), 32'(eg));
        checkOutput({tag, ".miss"}, 32'(miss), 32'(em));
        checkOutput({tag, ".score"}, 32'(score), 32'(es));
        checkOutput({tag, ".combo"}, 32'(combo), 32'(ec));
        checkOutput({tag, ".max_combo"}, 32'(max_combo), 32'(emx));
    endtask

    initial begin
        applyStimulus();
        applyStimulus();
        checkAll("reset", 5'b0, 5'b0, 5'b0, 0, 0, 0);
        rst = 1'b0;

        // lane 0 perfect at 660
        setH(0, 120);
        applyStimulus();
        for (int v = 640; v < 660; v++) begin
            setH(0, v);
            applyStimulus();
        end
        setH(0, 660); key[0] = 1'b1;
        applyStimulus();
        checkAll("perf0", 5'b00001, 5'b0, 5'b0, 2, 1, 1);
        setH(0, 661); key[0] = 1'b0;
        applyStimulus();
        checkAll("perf0_pulse_end", 5'b0, 5'b0, 5'b0, 2, 1, 1);
        setH(0, 720);
        applyStimulus();
        checkOutput("park_idle_no_miss", 32'(miss), 32'd0);

        // good at 630, second press ignored
        setH(0, 120);
        applyStimulus();
        setH(0, 630); key[0] = 1'b1;
        applyStimulus();
        checkAll("good0", 5'b0, 5'b00001, 5'b0, 3, 2, 2);
        setH(0, 640); key[0] = 1'b0;
        applyStimulus();
        setH(0, 650); key[0] = 1'b1;
        applyStimulus();
        checkAll("idle_press", 5'b0, 5'b0, 5'b0, 3, 2, 2);

        // build combo to 7, then miss
        for (int n = 0; n < 5; n++) begin
            setH(0, 120); key[0] = 1'b0;
            applyStimulus();
            setH(0, 660); key[0] = 1'b1;
            applyStimulus();
        end
        checkAll("combo7", 5'b00001, 5'b0, 5'b0, 13, 7, 7);
        setH(0, 120); key[0] = 1'b0;
        applyStimulus();
        setH(0, 699);
        applyStimulus();
        checkOutput("no_miss_at_699", 32'(miss), 32'd0);
        setH(0, 700);
        applyStimulus();
        checkAll("miss0", 5'b0, 5'b0, 5'b00001, 13, 0, 7);
        setH(0, 701);
        applyStimulus();
        checkOutput("miss0_pulse_end", 32'(miss), 32'd0);
        setH(0, 720);
        applyStimulus();

        // combo 10, then mixed same-cycle judgments
        for (int n = 0; n < 10; n++) begin
            setH(0, 120); key[0] = 1'b0;
            applyStimulus();
            setH(0, 660); key[0] = 1'b1;
            applyStimulus();
        end
        checkAll("combo10", 5'b00001, 5'b0, 5'b0, 33, 10, 10);
        key[0] = 1'b0;
        setH(1, 120); setH(2, 120); setH(3, 120);
        applyStimulus();
        setH(1, 660); key[1] = 1'b1;
        setH(2, 630); key[2] = 1'b1;
        setH(3, 700);
        applyStimulus();
        checkAll("mixed", 5'b00010, 5'b00100, 5'b01000, 36, 2, 10);
        key = '0;
        applyStimulus();
        checkAll("mixed_end", 5'b0, 5'b0, 5'b0, 36, 2, 10);

        // held key through the window, then miss
        setH(4, 120);
        applyStimulus();
        setH(4, 600); key[4] = 1'b1;
        applyStimulus();
        for (int v = 610; v <= 690; v += 10) begin
            setH(4, v);
            applyStimulus();
            checkOutput("held_no_hit", 32'(hit_perf | hit_good), 32'd0);
        end
        setH(4, 700);
        applyStimulus();
        checkAll("held_miss", 5'b0, 5'b0, 5'b10000, 36, 0, 10);

        // freeze during the window
        key[4] = 1'b0; setH(4, 120);
        applyStimulus();
        setH(4, 650);
        applyStimulus();
        stop_or_endgame = 1'b1; key[4] = 1'b1;
        applyStimulus();
        checkAll("frozen_press", 5'b0, 5'b0, 5'b0, 36, 0, 10);
        applyStimulus();
        checkAll("frozen_hold", 5'b0, 5'b0, 5'b0, 36, 0, 10);
        stop_or_endgame = 1'b0; setH(4, 655);
        applyStimulus();
        checkAll("resume_held", 5'b0, 5'b0, 5'b0, 36, 0, 10);
        key[4] = 1'b0;
        applyStimulus();
        checkAll("resume_release", 5'b0, 5'b0, 5'b0, 36, 0, 10);
        setH(4, 660); key[4] = 1'b1;
        applyStimulus();
        checkAll("resume_perf", 5'b10000, 5'b0, 5'b0, 38, 1, 10);

        // drive score to 9998 with all lanes
        for (int n = 0; n < 996; n++) begin
            setAllH(120); key = '0;
            applyStimulus();
            setAllH(660); key = 5'b11111;
            applyStimulus();
        end
        checkAll("score9998", 5'b11111, 5'b0, 5'b0, 9998, 255, 255);
        setAllH(120); key = '0;
        applyStimulus();
        setH(0, 660); key[0] = 1'b1;
        applyStimulus();
        checkAll("score_clamp", 5'b00001, 5'b0, 5'b0, 9999, 255, 255);
        setH(1, 660); key[1] = 1'b1;
        applyStimulus();
        checkAll("score_hold_max", 5'b00010, 5'b0, 5'b0, 9999, 255, 255);

        // restart mid-window discards the in-flight hit
        setH(2, 660); key[2] = 1'b1; restart = 1'b1;
        applyStimulus();
        checkAll("restart", 5'b0, 5'b0, 5'b0, 0, 0, 0);
        restart = 1'b0;
        applyStimulus();
        checkAll("after_restart", 5'b0, 5'b0, 5'b0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
